// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit in the EXE stage.
//
// This unit runs beside the ALU and owns the architectural HI/LO registers.
// mult/multu use a 32-step shift/add datapath. div/divu use a 32-step
// restoring divider. mthi/mtlo write HI/LO directly.
//
// Optional build macro: MULDIV_FAST_MULT_EN
//   - Defined: mult/multu skip RUN and form the product with one multiplier
//     in FIX, so a multiply takes 2 cycles from start to done.
//   - Undefined: multiply is iterative and no hardware multiplier is built.
//
// Ports:
//   CLK          clock
//   RESET        asynchronous active-low reset
//   start        issue request, qualified by !stall_in
//   ALU_control  6-bit op select:
//                  000101 div
//                  000110 divu
//                  001101 mult/multu
//                  001011 mthi
//                  001100 mtlo
//   is_signed    for 001101: 1 = mult, 0 = multu
//   A, B         rs / rt operands
//   stall_in     pipeline stall; blocks acceptance of start
//   flush        abort the in-flight operation
//   hilo_read    ID/EXE instruction is mfhi/mflo (also asserted for mt*)
//   HI_OUT       architectural HI
//   LO_OUT       architectural LO
//   busy         operation in flight
//   done         one-cycle pulse when mult/div update HI/LO
//   hilo_stall   busy & hilo_read
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [5:0]      ALU_control,
    input  logic            is_signed,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            hilo_read,
    output logic [XLEN-1:0] HI_OUT,
    output logic [XLEN-1:0] LO_OUT,
    output logic            busy,
    output logic            done,
    output logic            hilo_stall
);

    localparam logic [5:0] OP_DIV  = 6'b000101;
    localparam logic [5:0] OP_DIVU = 6'b000110;
    localparam logic [5:0] OP_MULT = 6'b001101;
    localparam logic [5:0] OP_MTHI = 6'b001011;
    localparam logic [5:0] OP_MTLO = 6'b001100;

    localparam int            CW       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_acc;     // mult: upper product half; div: remainder
    logic [XLEN-1:0]     r_mplr;    // mult: multiplier/lower half; div: dividend/quotient
    logic [XLEN-1:0]     r_opb;     // multiplicand or divisor magnitude
    logic                r_is_div;
    logic                r_neg_q;   // negate product or quotient in FIX
    logic                r_neg_r;   // negate remainder in FIX (sign of A)

    logic                w_accept, w_is_mul, w_is_div, w_op_signed, w_div0;
    logic [XLEN-1:0]     w_mag_a, w_mag_b;
    logic [XLEN:0]       w_mul_sum, w_rem_sh;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_sub;
    logic [2*XLEN-1:0]   w_prod, w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix, w_rem_fix;

    assign busy       = (r_state != S_IDLE);
    assign hilo_stall = busy & hilo_read;

    // Decode. Flush wins over a same-cycle start.
    assign w_accept    = start & ~stall_in & ~flush & (r_state == S_IDLE);
    assign w_is_mul    = (ALU_control == OP_MULT);
    assign w_is_div    = (ALU_control == OP_DIV) | (ALU_control == OP_DIVU);
    assign w_op_signed = w_is_mul ? is_signed : (ALU_control == OP_DIV);
    assign w_div0      = w_is_div & (B == '0);
    assign w_mag_a     = (w_op_signed & A[XLEN-1]) ? -A : A;
    assign w_mag_b     = (w_op_signed & B[XLEN-1]) ? -B : B;

    // One shift/add step. The carry out of the add shifts into acc's MSB.
    assign w_mul_sum = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_opb} : '0);

    // One restoring-divide step. When w_ge is set, the difference is below
    // the divisor, so the low XLEN bits of the subtraction are exact.
    assign w_rem_sh  = {r_acc, r_mplr[XLEN-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_opb;

`ifdef MULDIV_FAST_MULT_EN
    assign w_prod = {{XLEN{1'b0}}, r_mplr} * {{XLEN{1'b0}}, r_opb};
`else
    assign w_prod = {r_acc, r_mplr};
`endif
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_q ? -r_mplr : r_mplr;
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_div && !w_div0) begin
                    w_state_nxt = S_RUN;
                end else if (w_accept && w_is_mul) begin
`ifdef MULDIV_FAST_MULT_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (flush)                  w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HI_OUT   <= '0;
            LO_OUT   <= '0;
            done     <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mplr   <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div0) begin
                            done <= 1'b1;   // HI/LO keep their values
                        end else if (w_is_mul || w_is_div) begin
                            r_cnt    <= '0;
                            r_acc    <= '0;
                            r_mplr   <= w_mag_a;
                            r_opb    <= w_mag_b;
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_op_signed & (A[XLEN-1] ^ B[XLEN-1]);
                            r_neg_r  <= w_op_signed & A[XLEN-1];
                        end else if (ALU_control == OP_MTHI) begin
                            HI_OUT <= A;
                        end else if (ALU_control == OP_MTLO) begin
                            LO_OUT <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_is_div) begin
                            r_acc  <= w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                            r_mplr <= {r_mplr[XLEN-2:0], w_ge};
                        end else begin
                            r_acc  <= w_mul_sum[XLEN:1];
                            r_mplr <= {w_mul_sum[0], r_mplr[XLEN-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (r_is_div) begin
                            HI_OUT <= w_rem_fix;
                            LO_OUT <= w_quot_fix;
                        end else begin
                            HI_OUT <= w_prod_fix[2*XLEN-1:XLEN];
                            LO_OUT <= w_prod_fix[XLEN-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
